// File: rtl/nlp16_bus_arbiter_if.sv
// Signal bundle tying both bus masters and the memory slave to the arbiter.
// The arbiter attaches through 'slave' (it serves the masters); the surrounding system uses 'master'.
interface nlp16_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [15:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [15:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [15:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [15:0] m1_rdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy
  );
endinterface

// File: rtl/nlp16_bus_arbiter.sv
// Round-robin arbiter sharing the nlp16af memory bus between two word masters.
// Min 3 cycles per access; a waiting req is held off (never dropped) while another access is in flight.
module nlp16_bus_arbiter #(
  parameter int unsigned P_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  nlp16_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(P_TIMEOUT - 1);
  localparam bit          TO_EN   = (P_TIMEOUT != 0);

  state_t      state, state_nx;
  logic        last_grant, last_grant_nx;
  logic        gnt, gnt_nx;
  logic        rd_q, rd_nx;
  logic        wr_q, wr_nx;
  logic [15:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [15:0] rdata_q, rdata_nx;
  logic [15:0] cnt_q, cnt_nx;
  logic        ack0_q, ack0_nx;
  logic        ack1_q, ack1_nx;
  logic        err0_q, err0_nx;
  logic        err1_q, err1_nx;
  logic        busy_q, busy_nx;
  logic        sel;

  // On contention the master that did not win last time goes first.
  assign sel = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      cnt_q      <= 16'h0000;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      gnt        <= gnt_nx;
      rd_q       <= rd_nx;
      wr_q       <= wr_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      rdata_q    <= rdata_nx;
      cnt_q      <= cnt_nx;
      ack0_q     <= ack0_nx;
      ack1_q     <= ack1_nx;
      err0_q     <= err0_nx;
      err1_q     <= err1_nx;
      busy_q     <= busy_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    gnt_nx        = gnt;
    rd_nx         = rd_q;
    wr_nx         = wr_q;
    addr_nx       = addr_q;
    wdata_nx      = wdata_q;
    rdata_nx      = rdata_q;
    cnt_nx        = cnt_q;
    ack0_nx       = 1'b0;
    ack1_nx       = 1'b0;
    err0_nx       = 1'b0;
    err1_nx       = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_nx        = sel;
          last_grant_nx = sel;
          addr_nx       = sel ? bus.m1_addr  : bus.m0_addr;
          wdata_nx      = sel ? bus.m1_wdata : bus.m0_wdata;
          wr_nx         = sel ? bus.m1_we    : bus.m0_we;
          rd_nx         = sel ? ~bus.m1_we   : ~bus.m0_we;
          cnt_nx        = 16'h0000;
          state_nx      = ACCESS;
        end
      end
      ACCESS: begin
        // Ready takes priority over a timeout expiring in the same cycle.
        if (bus.mem_ready) begin
          if (rd_q) rdata_nx = bus.mem_rdata;
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          ack0_nx  = ~gnt;
          ack1_nx  = gnt;
          state_nx = DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          rdata_nx = 16'hFFFF;
          ack0_nx  = ~gnt;
          ack1_nx  = gnt;
          err0_nx  = ~gnt;
          err1_nx  = gnt;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.m0_rdata  = rdata_q;
  assign bus.m1_rdata  = rdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nlp16_bus_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level arbitration model.
module tb_nlp16_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nlp16_bus_arbiter_if bus();

  nlp16_bus_arbiter #(.P_TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 16'h0; bus.m0_wdata = 16'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 16'h0; bus.m1_wdata = 16'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_checks++;
    if ({bus.mem_rd, bus.mem_wr, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.busy} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0000000",
               {bus.mem_rd, bus.mem_wr, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.busy});
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (bus.mem_wdata !== 16'h0000) $display("FAIL reset_wdata got %h want 0000", bus.mem_wdata);
    else n_pass++;
    n_checks++;
    if (bus.m0_rdata !== 16'h0000 || bus.m1_rdata !== 16'h0000)
      $display("FAIL reset_rdata got %h/%h want 0000", bus.m0_rdata, bus.m1_rdata);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h1234;
    step();
    n_checks++;
    if ({bus.mem_rd, bus.mem_wr} !== 2'b10 || bus.mem_addr !== 16'h1234 || bus.busy !== 1'b1)
      $display("FAIL single_grant got rd/wr=%b addr=%h busy=%b want 10 1234 1",
               {bus.mem_rd, bus.mem_wr}, bus.mem_addr, bus.busy);
    else n_pass++;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'hBEEF;
    step();
    n_checks++;
    if ({bus.mem_rd, bus.mem_wr, bus.m1_ack, bus.m0_ack, bus.m0_err} !== 5'b00010)
      $display("FAIL single_ack got rd,wr,ack1,ack0,err=%b want 00010",
               {bus.mem_rd, bus.mem_wr, bus.m1_ack, bus.m0_ack, bus.m0_err});
    else n_pass++;
    n_checks++;
    if (bus.m0_rdata !== 16'hBEEF) $display("FAIL single_rdata got %h want beef", bus.m0_rdata);
    else n_pass++;
    bus.m0_req = 1'b0; bus.mem_ready = 1'b0;
    step();
    n_checks++;
    if ({bus.m1_ack, bus.m0_ack, bus.busy} !== 3'b000)
      $display("FAIL single_idle got ack1,ack0,busy=%b want 000", {bus.m1_ack, bus.m0_ack, bus.busy});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int t0 = -1, t1 = -1, first = -1, both = 0;
    do_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0100;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0200;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h7777;
    for (int c = 0; c < 20 && (t0 < 0 || t1 < 0); c++) begin
      step();
      if (bus.m0_ack && bus.m1_ack) both++;
      if (bus.m0_ack) begin if (first < 0) first = 0; t0 = c; bus.m0_req = 1'b0; end
      if (bus.m1_ack) begin if (first < 0) first = 1; t1 = c; bus.m1_req = 1'b0; end
    end
    bus.mem_ready = 1'b0;
    n_checks++;
    if (first !== 0) $display("FAIL simul_first got m%0d want m0", first);
    else n_pass++;
    n_checks++;
    if (t0 < 0 || t1 < 0 || (t1 - t0) !== 3)
      $display("FAIL simul_spacing got t0=%0d t1=%0d want t1-t0=3", t0, t1);
    else n_pass++;
    n_checks++;
    if (both !== 0) $display("FAIL simul_both_ack got %0d want 0", both);
    else n_pass++;
  endtask

  task automatic test_contention();
    int order[$];
    int times[$];
    int both = 0;
    do_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0A00;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0B00;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h3C3C;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      step();
      if (bus.m0_ack && bus.m1_ack) both++;
      if (bus.m0_ack) begin order.push_back(0); times.push_back(c); end
      if (bus.m1_ack) begin order.push_back(1); times.push_back(c); end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.mem_ready = 1'b0;
    step();
    n_checks++;
    if (order.size() !== 6) $display("FAIL cont_count got %0d want 6", order.size());
    else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++;
      if (order[i] !== (i % 2)) $display("FAIL cont_order[%0d] got m%0d want m%0d", i, order[i], i % 2);
      else n_pass++;
    end
    for (int i = 1; i < times.size(); i++) begin
      n_checks++;
      if (times[i] - times[i-1] !== 3)
        $display("FAIL cont_gap[%0d] got %0d want 3", i, times[i] - times[i-1]);
      else n_pass++;
    end
    n_checks++;
    if (both !== 0) $display("FAIL cont_both_ack got %0d want 0", both);
    else n_pass++;
  endtask

  task automatic test_write_wait();
    int wr_cycles = 0, unstable = 0;
    bit acked = 0;
    logic [3:0] a_flags = 4'b0;
    logic [15:0] a_rdata = 16'h0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0010; bus.m1_wdata = 16'h5A5A;
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 15 && !acked; c++) begin
      step();
      if (bus.mem_wr) begin
        wr_cycles++;
        if (bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'h5A5A || bus.mem_rd !== 1'b0) unstable++;
        bus.mem_ready = (wr_cycles == 3);
        bus.mem_rdata = 16'hDEAD;
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.m1_ack || bus.m0_ack) begin
        acked = 1;
        a_flags = {bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err};
        a_rdata = bus.m1_rdata;
        bus.m1_req = 1'b0;
      end
    end
    bus.mem_ready = 1'b0;
    n_checks++;
    if (wr_cycles !== 3) $display("FAIL write_strobe_len got %0d want 3", wr_cycles);
    else n_pass++;
    n_checks++;
    if (unstable !== 0) $display("FAIL write_stable got %0d unstable cycles want 0", unstable);
    else n_pass++;
    n_checks++;
    if (!acked || a_flags !== 4'b1000)
      $display("FAIL write_ack got acked=%0d ack1,ack0,err1,err0=%b want 1 1000", acked, a_flags);
    else n_pass++;
    n_checks++;
    if (a_rdata !== 16'h3C3C) $display("FAIL write_rdata got %h want 3c3c", a_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    for (int run = 0; run < 2; run++) begin
      int strobes = 0;
      bit acked = 0;
      logic a_err = 1'b0;
      logic [15:0] a_rdata = 16'h0;
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0ABC;
      bus.mem_ready = 1'b0;
      for (int c = 0; c < 20 && !acked; c++) begin
        step();
        if (bus.mem_rd) begin
          strobes++;
          bus.mem_ready = (run == 1) && (strobes == 4);
          bus.mem_rdata = 16'h1357;
        end else begin
          bus.mem_ready = 1'b0;
        end
        if (bus.m0_ack) begin
          acked = 1; a_err = bus.m0_err; a_rdata = bus.m0_rdata; bus.m0_req = 1'b0;
        end
      end
      bus.mem_ready = 1'b0;
      n_checks++;
      if (!acked || strobes !== 4)
        $display("FAIL timeout_len[%0d] got acked=%0d strobes=%0d want 1 4", run, acked, strobes);
      else n_pass++;
      n_checks++;
      if (a_err !== (run == 0)) $display("FAIL timeout_err[%0d] got %b want %b", run, a_err, run == 0);
      else n_pass++;
      n_checks++;
      if (a_rdata !== ((run == 0) ? 16'hFFFF : 16'h1357))
        $display("FAIL timeout_rdata[%0d] got %h want %h", run, a_rdata, (run == 0) ? 16'hFFFF : 16'h1357);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0F0F; bus.m1_wdata = 16'h1111;
    bus.mem_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({bus.mem_rd, bus.mem_wr, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.busy} !== 7'b0 ||
        bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.m1_rdata !== 16'h0)
      $display("FAIL midrst_state got ctrl=%b addr=%h wdata=%h rdata=%h want all zero",
               {bus.mem_rd, bus.mem_wr, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.busy},
               bus.mem_addr, bus.mem_wdata, bus.m1_rdata);
    else n_pass++;
    rst = 1'b0;
    bus.m1_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.m0_ack || bus.m1_ack || bus.mem_rd || bus.mem_wr) spurious++;
    end
    n_checks++;
    if (spurious !== 0) $display("FAIL midrst_no_ack got %0d active cycles want 0", spurious);
    else n_pass++;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h4444;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h5555;
    step();
    n_checks++;
    if (bus.mem_addr !== 16'h4444 || bus.mem_rd !== 1'b1)
      $display("FAIL midrst_next_grant got addr=%h rd=%b want 4444 1", bus.mem_addr, bus.mem_rd);
    else n_pass++;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h2468;
    step();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.mem_ready = 1'b0;
    step();
  endtask

  // Model: round-robin winner from who is requesting; outcome from the wait count the slave chose.
  task automatic test_random();
    logic        r_req   [2];
    logic        r_we    [2];
    logic [15:0] r_addr  [2];
    logic [15:0] r_wdata [2];
    bit          in_acc = 0;
    int          acc_idx = 0, w = 0, g = 0, done = 0;
    logic        exp_last = 1'b1;
    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] rv = 16'h0000;
    logic        strobe;
    for (int m = 0; m < 2; m++) begin
      r_req[m] = 1'b0; r_we[m] = 1'b0; r_addr[m] = 16'h0; r_wdata[m] = 16'h0;
    end
    do_reset();
    for (int cyc = 0; cyc < 6000 && done < 150; cyc++) begin
      step();
      strobe = bus.mem_rd | bus.mem_wr;
      bus.mem_ready = 1'b0;
      if (!in_acc && strobe) begin
        g = (r_req[0] && r_req[1]) ? (exp_last ? 0 : 1) : (r_req[1] ? 1 : 0);
        n_checks++;
        if (!(r_req[0] || r_req[1]) || bus.mem_addr !== r_addr[g] || bus.mem_wdata !== r_wdata[g] ||
            bus.mem_wr !== r_we[g] || bus.mem_rd !== !r_we[g])
          $display("FAIL rnd_grant cyc=%0d got addr=%h wr=%b want m%0d addr=%h wr=%b",
                   cyc, bus.mem_addr, bus.mem_wr, g, r_addr[g], r_we[g]);
        else n_pass++;
        exp_last = (g == 1);
        in_acc = 1; acc_idx = 0; w = $urandom_range(0, 5);
      end else if (in_acc && strobe) begin
        acc_idx++;
        n_checks++;
        if (bus.mem_addr !== r_addr[g] || bus.mem_wdata !== r_wdata[g] || bus.mem_wr !== r_we[g] ||
            bus.m0_ack || bus.m1_ack)
          $display("FAIL rnd_hold cyc=%0d got addr=%h wr=%b acks=%b want addr=%h wr=%b acks=00",
                   cyc, bus.mem_addr, bus.mem_wr, {bus.m1_ack, bus.m0_ack}, r_addr[g], r_we[g]);
        else n_pass++;
      end else if (in_acc && !strobe) begin
        if (w > 3) exp_rdata = 16'hFFFF;
        else if (!r_we[g]) exp_rdata = rv;
        n_checks++;
        if ({bus.m1_ack, bus.m0_ack} !== ((g == 1) ? 2'b10 : 2'b01) ||
            {bus.m1_err, bus.m0_err} !== ((w > 3) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00) ||
            bus.m0_rdata !== exp_rdata || bus.m1_rdata !== exp_rdata || acc_idx !== ((w > 3) ? 3 : w))
          $display("FAIL rnd_done cyc=%0d got acks=%b errs=%b rdata=%h len=%0d want m%0d w=%0d rdata=%h",
                   cyc, {bus.m1_ack, bus.m0_ack}, {bus.m1_err, bus.m0_err}, bus.m0_rdata, acc_idx,
                   g, w, exp_rdata);
        else n_pass++;
        in_acc = 0; done++;
        r_req[g] = ($urandom_range(0, 1) == 1);
        if (r_req[g]) begin
          r_we[g] = ($urandom_range(0, 1) == 1); r_addr[g] = 16'($urandom); r_wdata[g] = 16'($urandom);
        end
      end else begin
        n_checks++;
        if ({bus.m1_ack, bus.m0_ack} !== 2'b00)
          $display("FAIL rnd_idle cyc=%0d got acks=%b want 00", cyc, {bus.m1_ack, bus.m0_ack});
        else n_pass++;
      end
      if (in_acc && acc_idx == w) begin
        rv = 16'($urandom);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rv;
      end
      for (int m = 0; m < 2; m++) begin
        if (!r_req[m] && $urandom_range(0, 2) == 0) begin
          r_req[m] = 1'b1; r_we[m] = ($urandom_range(0, 1) == 1);
          r_addr[m] = 16'($urandom); r_wdata[m] = 16'($urandom);
        end
      end
      bus.m0_req = r_req[0]; bus.m0_we = r_we[0]; bus.m0_addr = r_addr[0]; bus.m0_wdata = r_wdata[0];
      bus.m1_req = r_req[1]; bus.m1_we = r_we[1]; bus.m1_addr = r_addr[1]; bus.m1_wdata = r_wdata[1];
    end
    idle_inputs();
    n_checks++;
    if (done !== 150) $display("FAIL rnd_progress got %0d completions want 150", done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_contention();
    test_write_wait();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
